// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S slave interface.
// State encodings and the default channel width.
package i2s_pkg;

    localparam int CH_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LDAT = 3'd1,
        ST_LWAI = 3'd2,
        ST_RDAT = 3'd3,
        ST_RWAI = 3'd4
    } state_e;

    function automatic logic is_data(input state_e s);
        return (s == ST_LDAT) || (s == ST_RDAT);
    endfunction

endpackage

// File: rtl/i2s_slave_if.sv
// Codec-side I2S endpoint: follows master LRCK, shifts one word
// each way per frame, with valid/ack word handshakes.
module i2s_slave_if
    import i2s_pkg::*;
#(
    parameter int CH_WIDTH = CH_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  LRCK,
    input  logic                  SDIN,
    output logic                  SDOUT,
    input  logic                  enable,
    input  logic [2*CH_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ack,
    output logic [2*CH_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic                  tx_underrun,
    output logic                  rx_overrun,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int FW = 2 * CH_WIDTH;
    localparam int CW = (CH_WIDTH > 1) ? $clog2(CH_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(CH_WIDTH - 1);

    state_e          state_q, state_d;
    logic            lrck_q;
    logic [FW-1:0]   tx_sh_q, tx_sh_d;
    logic [FW-1:0]   rx_sh_q, rx_sh_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;

    logic fall, rise, lr_edge;
    logic in_data, ferr, start, last, complete;
    logic [FW-1:0] rx_next;

    // LRCK shares clk with the master, so no synchroniser is needed
    assign fall    = lrck_q & ~LRCK;
    assign rise    = ~lrck_q & LRCK;
    assign lr_edge = fall | rise;

    assign in_data  = is_data(state_q);
    assign ferr     = in_data & lr_edge;
    assign start    = fall & enable &
                      ((state_q == ST_IDLE) || (state_q == ST_RWAI));
    assign last     = in_data & ~ferr & (cnt_q == '0);
    assign complete = last & (state_q == ST_RDAT);
    assign rx_next  = {rx_sh_q[FW-2:0], SDIN};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lrck_q     <= 1'b1;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            cnt_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lrck_q     <= LRCK;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            cnt_q      <= cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fall && enable) state_d = ST_LDAT;
            end
            ST_LDAT: begin
                if (lr_edge)            state_d = ST_IDLE;
                else if (cnt_q == '0)   state_d = ST_LWAI;
            end
            ST_LWAI: begin
                if (rise) state_d = ST_RDAT;
            end
            ST_RDAT: begin
                if (lr_edge)            state_d = ST_IDLE;
                else if (cnt_q == '0)   state_d = ST_RWAI;
            end
            ST_RWAI: begin
                if (fall) state_d = enable ? ST_LDAT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        cnt_d      = cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        if (start) begin
            tx_sh_d = tx_valid ? tx_data : '0;
            cnt_d   = CNT_TOP;
        end else if (ferr) begin
            rx_sh_d = '0;
        end else if (in_data) begin
            rx_sh_d = rx_next;
            tx_sh_d = {tx_sh_q[FW-2:0], 1'b0};
            cnt_d   = cnt_q - 1'b1;
        end else if ((state_q == ST_LWAI) && rise) begin
            cnt_d = CNT_TOP;
        end
        // An ack in the completion cycle is absorbed by the new word
        if (complete) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
        end else if (rx_ack) begin
            rx_valid_d = 1'b0;
        end
    end

    always_comb begin
        tx_ack      = start & tx_valid;
        tx_underrun = start & ~tx_valid;
        frame_err   = ferr;
        rx_overrun  = complete & rx_valid_q & ~rx_ack;
        SDOUT       = in_data ? tx_sh_q[FW-1] : 1'b0;
        busy        = (state_q != ST_IDLE);
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule
